// File: rtl/control_pkg.sv
// Shared RV32I encodings for the multicycle control unit: datapath mux selects
// and ISA field enums, plus small funct3 validity helpers.
package rv32i_mux_types;

    typedef enum logic [1:0] {
        pcmux_pc_plus4 = 2'b00,
        pcmux_alu_out  = 2'b01,
        pcmux_alu_mod2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic {
        marmux_pc_out  = 1'b0,
        marmux_alu_out = 1'b1
    } marmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out = 1'b0,
        alumux1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm   = 3'd0,
        alumux2_u_imm   = 3'd1,
        alumux2_b_imm   = 3'd2,
        alumux2_s_imm   = 3'd3,
        alumux2_j_imm   = 3'd4,
        alumux2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        regfilemux_alu_out  = 4'd0,
        regfilemux_br_en    = 4'd1,
        regfilemux_u_imm    = 4'd2,
        regfilemux_lw       = 4'd3,
        regfilemux_pc_plus4 = 4'd4,
        regfilemux_lb       = 4'd5,
        regfilemux_lbu      = 4'd6,
        regfilemux_lh       = 4'd7,
        regfilemux_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out = 1'b0,
        cmpmux_i_imm   = 1'b1
    } cmpmux_sel_t;

endpackage

package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    function automatic logic branch_f3_valid(logic [2:0] f);
        return (f != 3'b010) && (f != 3'b011);
    endfunction

    function automatic logic load_f3_valid(logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b101);
    endfunction

    function automatic logic store_f3_valid(logic [2:0] f);
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
    endfunction

endpackage

// File: rtl/control.sv
// Multicycle RV32I control unit: Moore sequencer driving datapath load enables,
// mux selects, ALU/compare ops and the memory request handshake.
//
// state    | meaning
// ---------+------------------------------------------------
// FETCH1   | PC -> MAR
// FETCH2   | instruction read, wait for mem_resp
// FETCH3   | MDR -> IR
// DECODE   | dispatch on opcode
// IMM      | register-immediate ALU op, PC+4
// REG      | register-register ALU op, PC+4
// LUI      | rd <- u_imm
// AUIPC    | rd <- PC + u_imm
// BR       | conditional branch
// JAL      | rd <- PC+4, PC <- PC + j_imm
// JALR     | rd <- PC+4, PC <- (rs1 + i_imm) & ~1
// CALC_LD  | load address -> MAR
// CALC_ST  | store address -> MAR, rs2 -> data_out
// LD1      | data read, wait for mem_resp
// LD2      | writeback loaded data, PC+4
// ST1      | data write, wait for mem_resp
// ST2      | PC+4
module control
    import rv32i_types::*;
    import rv32i_mux_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  rv32i_opcode     opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    input  logic [1:0]      mem_addr_lo,
    input  logic            mem_resp,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output pcmux_sel_t      pcmux_sel,
    output alumux1_sel_t    alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output regfilemux_sel_t regfilemux_sel,
    output marmux_sel_t     marmux_sel,
    output cmpmux_sel_t     cmpmux_sel,
    output alu_ops          aluop,
    output branch_funct3_t  cmpop,
    output logic            mem_read,
    output logic            mem_write,
    output logic [3:0]      mem_byte_enable
);

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR,
        JAL, JALR, CALC_LD, CALC_ST, LD1, LD2, ST1, ST2
    } state_t;

    state_t state, next_state;

    arith_funct3_t arith_f3;
    load_funct3_t  load_f3;
    store_funct3_t store_f3;
    logic          unused_funct7;

    assign arith_f3      = arith_funct3_t'(funct3);
    assign load_f3       = load_funct3_t'(funct3);
    assign store_f3      = store_funct3_t'(funct3);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH1;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH1:  next_state = FETCH2;
            FETCH2:  if (mem_resp) next_state = FETCH3;
            FETCH3:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    op_imm:   next_state = IMM;
                    op_reg:   next_state = REG;
                    op_lui:   next_state = LUI;
                    op_auipc: next_state = AUIPC;
                    op_br:    next_state = BR;
                    op_jal:   next_state = JAL;
                    op_jalr:  next_state = JALR;
                    op_load:  next_state = CALC_LD;
                    op_store: next_state = CALC_ST;
                    default:  next_state = FETCH1;
                endcase
            end
            CALC_LD: next_state = LD1;
            CALC_ST: next_state = ST1;
            LD1:     if (mem_resp) next_state = LD2;
            // An undefined store width never issues a write, so there is nothing to wait for.
            ST1:     if (mem_resp || !store_f3_valid(funct3)) next_state = ST2;
            default: next_state = FETCH1;
        endcase
    end

    always_comb begin
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = pcmux_pc_plus4;
        alumux1_sel     = alumux1_rs1_out;
        alumux2_sel     = alumux2_i_imm;
        regfilemux_sel  = regfilemux_alu_out;
        marmux_sel      = marmux_pc_out;
        cmpmux_sel      = cmpmux_rs2_out;
        aluop           = alu_add;
        cmpop           = beq;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b0000;

        if (!rst) begin
            case (state)
                FETCH1: begin
                    marmux_sel = marmux_pc_out;
                    load_mar   = 1'b1;
                end
                FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                end
                FETCH3: load_ir = 1'b1;
                IMM, REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    aluop        = alu_ops'(funct3);
                    alumux2_sel  = (state == REG) ? alumux2_rs2_out : alumux2_i_imm;
                    case (arith_f3)
                        slt, sltu: begin
                            cmpop          = (arith_f3 == slt) ? blt : bltu;
                            regfilemux_sel = regfilemux_br_en;
                            if (state == IMM) cmpmux_sel = cmpmux_i_imm;
                        end
                        sr:      if (funct7[5]) aluop = alu_sra;
                        add:     if (state == REG && funct7[5]) aluop = alu_sub;
                        default: ;
                    endcase
                end
                LUI: begin
                    regfilemux_sel = regfilemux_u_imm;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                end
                AUIPC: begin
                    alumux1_sel  = alumux1_pc_out;
                    alumux2_sel  = alumux2_u_imm;
                    aluop        = alu_add;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                end
                BR: begin
                    load_pc = 1'b1;
                    if (branch_f3_valid(funct3)) begin
                        cmpop       = branch_funct3_t'(funct3);
                        cmpmux_sel  = cmpmux_rs2_out;
                        alumux1_sel = alumux1_pc_out;
                        alumux2_sel = alumux2_b_imm;
                        aluop       = alu_add;
                        if (br_en) pcmux_sel = pcmux_alu_out;
                    end
                end
                JAL, JALR: begin
                    regfilemux_sel = regfilemux_pc_plus4;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    aluop          = alu_add;
                    if (state == JAL) begin
                        alumux1_sel = alumux1_pc_out;
                        alumux2_sel = alumux2_j_imm;
                        pcmux_sel   = pcmux_alu_out;
                    end else begin
                        alumux1_sel = alumux1_rs1_out;
                        alumux2_sel = alumux2_i_imm;
                        pcmux_sel   = pcmux_alu_mod2;
                    end
                end
                CALC_LD: begin
                    alumux2_sel = alumux2_i_imm;
                    aluop       = alu_add;
                    marmux_sel  = marmux_alu_out;
                    load_mar    = 1'b1;
                end
                CALC_ST: begin
                    alumux2_sel   = alumux2_s_imm;
                    aluop         = alu_add;
                    marmux_sel    = marmux_alu_out;
                    load_mar      = 1'b1;
                    load_data_out = 1'b1;
                end
                LD1: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                end
                LD2: begin
                    load_pc      = 1'b1;
                    load_regfile = load_f3_valid(funct3);
                    case (load_f3)
                        lb:      regfilemux_sel = regfilemux_lb;
                        lh:      regfilemux_sel = regfilemux_lh;
                        lw:      regfilemux_sel = regfilemux_lw;
                        lbu:     regfilemux_sel = regfilemux_lbu;
                        lhu:     regfilemux_sel = regfilemux_lhu;
                        default: regfilemux_sel = regfilemux_alu_out;
                    endcase
                end
                ST1: begin
                    case (store_f3)
                        sw: begin
                            mem_write       = 1'b1;
                            mem_byte_enable = 4'b1111;
                        end
                        sh: begin
                            mem_write       = 1'b1;
                            mem_byte_enable = 4'b0011 << {mem_addr_lo[1], 1'b0};
                        end
                        sb: begin
                            mem_write       = 1'b1;
                            mem_byte_enable = 4'b0001 << mem_addr_lo;
                        end
                        default: ;
                    endcase
                end
                ST2: load_pc = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the multicycle control unit: a per-instruction plan of
// expected control words is built from the ISA rules and compared every cycle.
module tb_control;
    import rv32i_types::*;
    import rv32i_mux_types::*;

    typedef struct packed {
        logic            load_pc;
        logic            load_ir;
        logic            load_regfile;
        logic            load_mar;
        logic            load_mdr;
        logic            load_data_out;
        pcmux_sel_t      pcmux;
        alumux1_sel_t    a1;
        alumux2_sel_t    a2;
        regfilemux_sel_t rf;
        marmux_sel_t     mar;
        cmpmux_sel_t     cmp;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      be;
    } ctl_t;

    typedef struct {
        ctl_t c;
        bit   mem;
    } step_t;

    logic            clk = 1'b0;
    logic            rst;
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic [1:0]      mem_addr_lo;
    logic            mem_resp;
    logic            load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    pcmux_sel_t      pcmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            mem_read, mem_write;
    logic [3:0]      mem_byte_enable;

    control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable)
    );

    always #5 clk = ~clk;

    ctl_t       act, exp_ctl;
    logic       exp_valid = 1'b0;
    int         n_checks = 0, n_pass = 0, cyc = 0;
    int         seen_read, seen_write;
    logic [3:0] seen_be;
    step_t      plan[$];
    logic [3:0] byte_lane [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    assign act = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
                  pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
                  cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable};

    always @(negedge clk) begin
        cyc++;
        if (exp_valid) begin
            n_checks++;
            if (act === exp_ctl) n_pass++;
            else $display("FAIL ctl_word cyc=%0d got=%h want=%h", cyc, act, exp_ctl);
            if (mem_read) seen_read++;
            if (mem_write) begin
                seen_write++;
                seen_be = mem_byte_enable;
            end
        end
    end

    function automatic ctl_t idle();
        ctl_t c;
        c.load_pc = 0; c.load_ir = 0; c.load_regfile = 0;
        c.load_mar = 0; c.load_mdr = 0; c.load_data_out = 0;
        c.pcmux = pcmux_pc_plus4; c.a1 = alumux1_rs1_out; c.a2 = alumux2_i_imm;
        c.rf = regfilemux_alu_out; c.mar = marmux_pc_out; c.cmp = cmpmux_rs2_out;
        c.aluop = alu_add; c.cmpop = beq;
        c.mem_read = 0; c.mem_write = 0; c.be = 4'b0000;
        return c;
    endfunction

    task automatic push(ctl_t c, bit mem);
        step_t s;
        s.c = c;
        s.mem = mem;
        plan.push_back(s);
    endtask

    // Expected control word for every cycle of one instruction, from fetch to retire.
    task automatic plan_instr(rv32i_opcode op, logic [2:0] f3, logic [6:0] f7,
                              logic br, logic [1:0] lo);
        ctl_t c;
        bit   is_reg;
        plan.delete();
        c = idle(); c.load_mar = 1; c.mar = marmux_pc_out;  push(c, 0);
        c = idle(); c.mem_read = 1; c.load_mdr = 1;         push(c, 1);
        c = idle(); c.load_ir = 1;                          push(c, 0);
        c = idle();                                         push(c, 0);
        is_reg = (op == op_reg);
        c = idle();
        case (op)
            op_imm, op_reg: begin
                c.load_regfile = 1; c.load_pc = 1;
                c.a2 = is_reg ? alumux2_rs2_out : alumux2_i_imm;
                case (f3)
                    3'b000: c.aluop = (is_reg && f7[5]) ? alu_sub : alu_add;
                    3'b001: c.aluop = alu_sll;
                    3'b010, 3'b011: begin
                        c.aluop = alu_ops'(f3);
                        c.rf    = regfilemux_br_en;
                        c.cmpop = (f3 == 3'b010) ? blt : bltu;
                        c.cmp   = is_reg ? cmpmux_rs2_out : cmpmux_i_imm;
                    end
                    3'b100: c.aluop = alu_xor;
                    3'b101: c.aluop = f7[5] ? alu_sra : alu_srl;
                    3'b110: c.aluop = alu_or;
                    default: c.aluop = alu_and;
                endcase
                push(c, 0);
            end
            op_lui: begin
                c.rf = regfilemux_u_imm; c.load_regfile = 1; c.load_pc = 1;
                push(c, 0);
            end
            op_auipc: begin
                c.a1 = alumux1_pc_out; c.a2 = alumux2_u_imm;
                c.load_regfile = 1; c.load_pc = 1;
                push(c, 0);
            end
            op_br: begin
                c.load_pc = 1;
                if (!(f3 inside {3'b010, 3'b011})) begin
                    c.cmpop = branch_funct3_t'(f3); c.cmp = cmpmux_rs2_out;
                    c.a1 = alumux1_pc_out; c.a2 = alumux2_b_imm;
                    c.pcmux = br ? pcmux_alu_out : pcmux_pc_plus4;
                end
                push(c, 0);
            end
            op_jal, op_jalr: begin
                c.rf = regfilemux_pc_plus4; c.load_regfile = 1; c.load_pc = 1;
                c.a1 = (op == op_jal) ? alumux1_pc_out : alumux1_rs1_out;
                c.a2 = (op == op_jal) ? alumux2_j_imm : alumux2_i_imm;
                c.pcmux = (op == op_jal) ? pcmux_alu_out : pcmux_alu_mod2;
                push(c, 0);
            end
            op_load: begin
                c.mar = marmux_alu_out; c.load_mar = 1;                     push(c, 0);
                c = idle(); c.mem_read = 1; c.load_mdr = 1;                 push(c, 1);
                c = idle(); c.load_pc = 1; c.load_regfile = 1;
                case (f3)
                    3'b000: c.rf = regfilemux_lb;
                    3'b001: c.rf = regfilemux_lh;
                    3'b010: c.rf = regfilemux_lw;
                    3'b100: c.rf = regfilemux_lbu;
                    3'b101: c.rf = regfilemux_lhu;
                    default: c.load_regfile = 0;
                endcase
                push(c, 0);
            end
            op_store: begin
                c.a2 = alumux2_s_imm; c.mar = marmux_alu_out;
                c.load_mar = 1; c.load_data_out = 1;                        push(c, 0);
                c = idle();
                if (f3 <= 3'b010) begin
                    c.mem_write = 1;
                    c.be = (f3 == 3'b010) ? 4'b1111 :
                           (f3 == 3'b001) ? (byte_lane[{lo[1], 1'b0}] | byte_lane[{lo[1], 1'b1}]) :
                                            byte_lane[lo];
                    push(c, 1);
                end else begin
                    push(c, 0);
                end
                c = idle(); c.load_pc = 1;                                  push(c, 0);
            end
            default: ;
        endcase
    endtask

    task automatic check(string name, int got, int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic cycle(ctl_t e, logic resp);
        mem_resp  = resp;
        exp_ctl   = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
    endtask

    // fwait/mwait: cycles mem_resp is withheld (-1 = random); rst_in_mem resets inside the data wait.
    task automatic run_instr(rv32i_opcode op, logic [2:0] f3, logic [6:0] f7, logic br,
                             logic [1:0] lo, int fwait, int mwait, bit rst_in_mem);
        int w;
        opcode = op; funct3 = f3; funct7 = f7; br_en = br; mem_addr_lo = lo;
        plan_instr(op, f3, f7, br, lo);
        seen_read = 0; seen_write = 0; seen_be = 4'b0000;
        for (int i = 0; i < plan.size(); i++) begin
            if (plan[i].mem) begin
                w = (i == 1) ? fwait : mwait;
                if (w < 0) w = $urandom_range(0, 3);
                if (rst_in_mem && i > 1) begin
                    cycle(plan[i].c, 1'b0);
                    rst = 1'b1;
                    exp_ctl = idle();
                    #2;
                    check("rst_mem_read", int'(mem_read), 0);
                    check("rst_load_regfile", int'(load_regfile), 0);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    return;
                end
                repeat (w) cycle(plan[i].c, 1'b0);
                cycle(plan[i].c, 1'b1);
            end else begin
                cycle(plan[i].c, (i > 0 && !plan[i-1].mem && $urandom_range(0, 3) == 0));
            end
        end
    endtask

    rv32i_opcode ops [10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                              op_load, op_store, op_imm, op_reg, op_csr};

    initial begin
        rv32i_opcode op;
        rst = 1'b1; opcode = op_imm; funct3 = 3'b000; funct7 = 7'b0;
        br_en = 1'b0; mem_addr_lo = 2'b00; mem_resp = 1'b0;
        @(posedge clk);
        #1;
        exp_ctl = idle();
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // addi x1,x0,5: five cycles, then back in FETCH1
        plan_instr(op_imm, 3'b000, 7'b0, 1'b0, 2'b00);
        check("addi_plan_len", plan.size(), 5);
        check("addi_plan_aluop", int'(plan[4].c.aluop), int'(alu_add));
        run_instr(op_imm, 3'b000, 7'b0, 1'b0, 2'b00, 0, 0, 0);
        #2;
        check("addi_cycle6_load_mar", int'(load_mar), 1);

        plan_instr(op_imm, 3'b101, 7'b0100000, 1'b0, 2'b00);
        check("srai_plan_aluop", int'(plan[4].c.aluop), int'(alu_sra));
        run_instr(op_imm, 3'b101, 7'b0100000, 1'b0, 2'b00, 0, 0, 0);
        plan_instr(op_imm, 3'b101, 7'b0000000, 1'b0, 2'b00);
        check("srli_plan_aluop", int'(plan[4].c.aluop), int'(alu_srl));
        run_instr(op_imm, 3'b101, 7'b0000000, 1'b0, 2'b00, 0, 0, 0);
        run_instr(op_reg, 3'b000, 7'b0100000, 1'b0, 2'b00, 1, 0, 0);

        plan_instr(op_br, 3'b000, 7'b0, 1'b1, 2'b00);
        check("beq_taken_pcmux", int'(plan[4].c.pcmux), int'(pcmux_alu_out));
        run_instr(op_br, 3'b000, 7'b0, 1'b1, 2'b00, 0, 0, 0);
        plan_instr(op_br, 3'b000, 7'b0, 1'b0, 2'b00);
        check("beq_not_taken_pcmux", int'(plan[4].c.pcmux), int'(pcmux_pc_plus4));
        run_instr(op_br, 3'b000, 7'b0, 1'b0, 2'b00, 0, 0, 0);

        run_instr(op_store, 3'b000, 7'b0, 1'b0, 2'b10, 0, 2, 0);
        check("sb_lane2_be", int'(seen_be), 4'b0100);
        check("sb_write_cycles", seen_write, 3);
        run_instr(op_store, 3'b001, 7'b0, 1'b0, 2'b11, 0, 0, 0);
        check("sh_upper_be", int'(seen_be), 4'b1100);
        run_instr(op_store, 3'b011, 7'b0, 1'b0, 2'b00, 0, 0, 0);
        check("bad_store_no_write", seen_write, 0);

        run_instr(op_lui, 3'b000, 7'b0, 1'b0, 2'b00, 3, 0, 0);
        check("fetch_wait_read_cycles", seen_read, 4);

        plan_instr(op_load, 3'b010, 7'b0, 1'b0, 2'b00);
        check("lw_plan_len", plan.size(), 7);
        run_instr(op_load, 3'b010, 7'b0, 1'b0, 2'b00, 0, 0, 0);
        run_instr(op_load, 3'b010, 7'b0, 1'b0, 2'b00, 0, 3, 1);

        plan_instr(rv32i_opcode'(7'b0000000), 3'b000, 7'b0, 1'b0, 2'b00);
        check("illegal_plan_len", plan.size(), 4);
        run_instr(rv32i_opcode'(7'b0000000), 3'b000, 7'b0, 1'b0, 2'b00, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) op = rv32i_opcode'(7'($urandom));
            else                           op = ops[$urandom_range(0, 9)];
            run_instr(op, 3'($urandom), ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom),
                      1'($urandom), 2'($urandom), -1, -1, ($urandom_range(0, 19) == 0));
        end

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
